// File: rtl/pll_rst_pkg.sv
// +----------------------------------------------------------------------+
// | pll_rst_pkg: shared types and constants for the PLL reset sequencer  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        SDRAM_UP  = 3'd2,
        CAM_UP    = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int         DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int         DEF_STAGE_GAP          = 256;
    localparam logic [7:0] LOSS_CNT_MAX           = 8'd255;

    // Domain reset pattern {sdram, cam, vga, ready} presented while in a state.
    function automatic logic [3:0] domain_outputs(input state_t s);
        case (s)
            SDRAM_UP: domain_outputs = 4'b1000;
            CAM_UP:   domain_outputs = 4'b1100;
            RUN:      domain_outputs = 4'b1111;
            default:  domain_outputs = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_bit_sync.sv
// +----------------------------------------------------------------------+
// | cdc_bit_sync: single-bit flop-chain synchronizer, sync active-low rst |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module cdc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_rst_seq.sv
// +----------------------------------------------------------------------+
// | pll_rst_seq: qualifies PLL lock and releases SDRAM/camera/VGA resets |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP          = DEF_STAGE_GAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       sw_reset_i,
    output logic       sdram_rst_n_o,
    output logic       cam_rst_n_o,
    output logic       vga_rst_n_o,
    output logic       sys_ready_o,
    output logic [7:0] lock_loss_cnt_o,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2((LOCK_STABLE_CYCLES > STAGE_GAP) ?
                                  LOCK_STABLE_CYCLES : STAGE_GAP) + 1;
    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic             w_lock_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_dom;
    logic [7:0]       r_loss_cnt;

    cdc_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_i),
        .q     (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == WAIT_LOCK) begin
            w_cnt_nxt = '0;
            if (w_lock_s) begin
                w_state_nxt = STABILIZE;
                w_cnt_nxt   = c_one;
            end
        // Lock loss takes priority; both aborts land in WAIT_LOCK identically.
        end else if (!w_lock_s || sw_reset_i) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                STABILIZE: begin
                    if (r_cnt == c_stable_last) begin
                        w_state_nxt = SDRAM_UP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                SDRAM_UP, CAM_UP: begin
                    if (r_cnt == c_gap_last) begin
                        w_state_nxt = (r_state == SDRAM_UP) ? CAM_UP : RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                RUN: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_dom      <= 4'b0000;
            r_loss_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dom   <= domain_outputs(w_state_nxt);
            // Any non-WAIT state implies lock_s was high last cycle, so low now is a 1->0 edge.
            if (r_state != WAIT_LOCK && !w_lock_s && r_loss_cnt != LOSS_CNT_MAX) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    assign sdram_rst_n_o   = r_dom[3];
    assign cam_rst_n_o     = r_dom[2];
    assign vga_rst_n_o     = r_dom[1];
    assign sys_ready_o     = r_dom[0];
    assign lock_loss_cnt_o = r_loss_cnt;
    assign state_o         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
// +----------------------------------------------------------------------+
// | tb_pll_rst_seq: directed + randomized bench with a timeline model     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pll_rst_seq;

    localparam int L = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       sw_reset_i = 1'b0;
    logic       sdram_rst_n_o;
    logic       cam_rst_n_o;
    logic       vga_rst_n_o;
    logic       sys_ready_o;
    logic [7:0] lock_loss_cnt_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: m_up counts edges since leaving WAIT_LOCK (1 on the entry edge).
    int m_up   = 0;
    int m_loss = 0;
    bit m_s1   = 1'b0;
    bit m_ls   = 1'b0;

    pll_rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP          (G)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked_i    (pll_locked_i),
        .sw_reset_i      (sw_reset_i),
        .sdram_rst_n_o   (sdram_rst_n_o),
        .cam_rst_n_o     (cam_rst_n_o),
        .vga_rst_n_o     (vga_rst_n_o),
        .sys_ready_o     (sys_ready_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    function automatic int m_state();
        if (m_up == 0)              return 0;
        else if (m_up < L)          return 1;
        else if (m_up < L + G)      return 2;
        else if (m_up < L + 2 * G)  return 3;
        else                        return 4;
    endfunction

    task automatic model_edge();
        bit ls_old;
        if (!rst_n) begin
            m_up = 0; m_loss = 0; m_s1 = 1'b0; m_ls = 1'b0;
        end else begin
            ls_old = m_ls;
            if (m_up == 0) begin
                if (ls_old) m_up = 1;
            end else if (!ls_old || sw_reset_i) begin
                if (!ls_old && m_loss < 255) m_loss++;
                m_up = 0;
            end else if (m_up < 1000) begin
                m_up++;
            end
            m_ls = m_s1;
            m_s1 = pll_locked_i;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sdram", {7'd0, sdram_rst_n_o}, {7'd0, m_up >= L});
        check("cam",   {7'd0, cam_rst_n_o},   {7'd0, m_up >= L + G});
        check("vga",   {7'd0, vga_rst_n_o},   {7'd0, m_up >= L + 2 * G});
        check("ready", {7'd0, sys_ready_o},   {7'd0, m_up >= L + 2 * G});
        check("loss",  lock_loss_cnt_o,       8'(m_loss));
        check("state", {5'd0, state_o},       8'(m_state()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state() != target && n < budget) begin
            step();
            n++;
        end
        check(tag, {5'd0, state_o}, 8'(target));
    endtask

    initial begin
        // 1: reset with lock high, then full release sequence
        rst_n = 1'b0; pll_locked_i = 1'b1;
        run(5);
        rst_n = 1'b1;
        run(2 + L + 2 * G + 4);
        check("s1_run_state", {5'd0, state_o}, 8'd4);

        // 2: dropout during qualification
        rst_n = 1'b0; pll_locked_i = 1'b0;
        run(2);
        rst_n = 1'b1;
        pll_locked_i = 1'b1; run(5);
        pll_locked_i = 1'b0; run(3);
        pll_locked_i = 1'b1; run(L + 2 * G + 6);
        check("s2_loss", lock_loss_cnt_o, 8'd1);

        // 3: lock loss in RUN
        wait_state(4, 100, "s3_reach_run");
        pll_locked_i = 1'b0; run(10);
        pll_locked_i = 1'b1; run(L + 2 * G + 6);
        check("s3_loss", lock_loss_cnt_o, 8'd2);

        // 4: soft reset in CAM_UP
        pll_locked_i = 1'b0; run(4);
        pll_locked_i = 1'b1;
        wait_state(3, 100, "s4_reach_cam");
        sw_reset_i = 1'b1; step();
        sw_reset_i = 1'b0;
        check("s4_state_wait", {5'd0, state_o}, 8'd0);
        run(L + 2 * G + 4);
        check("s4_loss", lock_loss_cnt_o, 8'd3);

        // randomized lock runs and soft-reset pulses
        for (int k = 0; k < 60; k++) begin
            int len;
            pll_locked_i = ($urandom_range(0, 3) != 0);
            len = pll_locked_i ? $urandom_range(1, 40) : $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                sw_reset_i = ($urandom_range(0, 29) == 0);
                step();
            end
            sw_reset_i = 1'b0;
        end

        // 5: repeated loss events saturate the counter
        for (int k = 0; k < 300; k++) begin
            pll_locked_i = 1'b1; run($urandom_range(3, 6));
            pll_locked_i = 1'b0; run($urandom_range(3, 4));
        end
        check("s5_loss_sat", lock_loss_cnt_o, 8'd255);

        // 6: rst_n asserted in SDRAM_UP
        pll_locked_i = 1'b1;
        wait_state(2, 100, "s6_reach_sdram");
        rst_n = 1'b0; step();
        check("s6_sdram_low", {7'd0, sdram_rst_n_o}, 8'd0);
        check("s6_loss_clr", lock_loss_cnt_o, 8'd0);
        rst_n = 1'b1;
        run(L + 2 * G + 6);
        check("s6_rerun_state", {5'd0, state_o}, 8'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
